// File: rtl/stream_argmin.sv
// rtl/stream_argmin.sv - windowed streaming argmin over LANES candidates per beat, BEATS beats per window.
// Optional STREAM_ARGMIN_UNIQ_EN adds second-minimum tracking for the out_uniq flag.
module stream_argmin #(
  parameter int DATA_W      = 8,
  parameter int LANES       = 4,
  parameter int BEATS       = 16,
  parameter int IDX_W       = 10,
  parameter int IDX_OFFSET  = 0,
  parameter int UNIQ_MARGIN = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W*LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_min,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_uniq
);

  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (LANES < 2 || LANES > 64) begin : g_bad_lanes
    $error("stream_argmin: LANES out of range");
  end
  if (BEATS < 1 || BEATS > 256) begin : g_bad_beats
    $error("stream_argmin: BEATS out of range");
  end
  if (LANES * BEATS + IDX_OFFSET > (1 << IDX_W)) begin : g_bad_idx
    $error("stream_argmin: IDX_W too narrow");
  end
  if (UNIQ_MARGIN < 0 || (UNIQ_MARGIN >> DATA_W) != 0) begin : g_bad_margin
    $error("stream_argmin: UNIQ_MARGIN does not fit DATA_W");
  end

  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] acc_min;
  logic [IDX_W-1:0]  acc_idx;

  logic [DATA_W-1:0] beat_min;
  logic [LANE_W-1:0] lane_idx;
  logic [DATA_W-1:0] lane;
  logic [IDX_W-1:0]  beat_idx;
  logic              first;
  logic              last;
  logic              accept;
  logic              take;
  logic [DATA_W-1:0] nxt_min;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_uniq;

`ifdef STREAM_ARGMIN_UNIQ_EN
  logic [DATA_W-1:0] acc_sec;
  logic [DATA_W-1:0] beat_sec;
  logic [DATA_W-1:0] nxt_sec;
`endif

  // Per-beat reduction; strict compare keeps the lowest lane on ties.
  always_comb begin
    beat_min = in_data[0 +: DATA_W];
    lane_idx = '0;
    lane     = '0;
`ifdef STREAM_ARGMIN_UNIQ_EN
    beat_sec = '1;
`endif
    for (int k = 1; k < LANES; k++) begin
      lane = in_data[k*DATA_W +: DATA_W];
      if (lane < beat_min) begin
`ifdef STREAM_ARGMIN_UNIQ_EN
        beat_sec = beat_min;
`endif
        beat_min = lane;
        lane_idx = LANE_W'(k);
      end
`ifdef STREAM_ARGMIN_UNIQ_EN
      else if (lane < beat_sec) begin
        beat_sec = lane;
      end
`endif
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (beat_cnt == '0);
  assign last     = (beat_cnt == LAST_BEAT);
  assign beat_idx = IDX_W'(beat_cnt) * IDX_W'(LANES) + IDX_W'(lane_idx) + IDX_W'(IDX_OFFSET);
  assign take     = first || (beat_min < acc_min);
  assign nxt_min  = take ? beat_min : acc_min;
  assign nxt_idx  = take ? beat_idx : acc_idx;

`ifdef STREAM_ARGMIN_UNIQ_EN
  // A displaced minimum becomes a second-min candidate; a losing or tying beat_min does too.
  always_comb begin
    if (first) begin
      nxt_sec = beat_sec;
    end else if (take) begin
      nxt_sec = (acc_min < beat_sec) ? acc_min : beat_sec;
    end else begin
      nxt_sec = (beat_min < acc_sec) ? beat_min : acc_sec;
    end
  end
  assign nxt_uniq = ({1'b0, nxt_sec} - {1'b0, nxt_min}) > (DATA_W+1)'(UNIQ_MARGIN);
`else
  assign nxt_uniq = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      acc_min   <= '0;
      acc_idx   <= '0;
`ifdef STREAM_ARGMIN_UNIQ_EN
      acc_sec   <= '0;
`endif
      out_valid <= 1'b0;
      out_min   <= '0;
      out_idx   <= '0;
      out_uniq  <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        acc_min  <= nxt_min;
        acc_idx  <= nxt_idx;
`ifdef STREAM_ARGMIN_UNIQ_EN
        acc_sec  <= nxt_sec;
`endif
      end
      // in_ready guarantees the old result is gone whenever a last beat lands.
      if (accept && last) begin
        out_valid <= 1'b1;
        out_min   <= nxt_min;
        out_idx   <= nxt_idx;
        out_uniq  <= nxt_uniq;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_argmin.sv
// tb/tb_stream_argmin.sv - randomized self-checking bench for stream_argmin against a window-level model.
module tb_stream_argmin;
  localparam int DW     = 8;
  localparam int LN     = 4;
  localparam int BT     = 2;
  localparam int NC     = LN * BT;
  localparam int IW     = 10;
  localparam int MARGIN = 2;
`ifdef STREAM_ARGMIN_UNIQ_EN
  localparam bit UNIQ_ON = 1'b1;
`else
  localparam bit UNIQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW*LN-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_min;
  logic [IW-1:0] out_idx;
  logic          out_uniq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;
  logic [18:0] expq[$];
  int hs_cyc[$];

  always #5 clk = ~clk;

  stream_argmin #(
    .DATA_W(DW), .LANES(LN), .BEATS(BT), .IDX_W(IW), .IDX_OFFSET(0), .UNIQ_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_idx(out_idx),
    .out_uniq(out_uniq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole-window reference: first occurrence of the minimum, smallest cost elsewhere.
  task automatic model(input logic [7:0] c[NC], output logic [18:0] e);
    int mi;
    int sec;
    logic u;
    mi = 0;
    for (int i = 1; i < NC; i++) if (c[i] < c[mi]) mi = i;
    sec = 255;
    for (int i = 0; i < NC; i++) if (i != mi && int'(c[i]) < sec) sec = int'(c[i]);
    u = UNIQ_ON ? ((sec - int'(c[mi])) > MARGIN) : 1'b1;
    e = {c[mi], 10'(mi), u};
  endtask

  task automatic monitor();
    logic pv, pr, pu;
    logic [7:0] pm;
    logic [9:0] pi;
    logic [18:0] e;
    pv = 1'b0; pr = 1'b0; pu = 1'b0; pm = '0; pi = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pv && !pr && rst_n) begin
        check("hold_valid", out_valid, 1);
        check("hold_min", out_min, pm);
        check("hold_idx", out_idx, pi);
        check("hold_uniq", out_uniq, pu);
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = expq.pop_front();
          check("min", out_min, e[18:11]);
          check("idx", out_idx, e[10:1]);
          check("uniq", out_uniq, e[0]);
        end
      end
      pv = out_valid; pr = out_ready; pm = out_min; pi = out_idx; pu = out_uniq;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 300);
    in_valid = 1'b0;
    in_data  = $urandom;
    if (!ok) check("beat_timeout", 0, 1);
  endtask

  task automatic send_window(input logic [7:0] c[NC], input int gap_max, input bit push);
    logic [18:0] e;
    logic [31:0] d;
    if (push) begin
      model(c, e);
      expq.push_back(e);
    end
    for (int b = 0; b < BT; b++) begin
      d = {c[b*LN+3], c[b*LN+2], c[b*LN+1], c[b*LN]};
      send_beat(d);
      repeat ($urandom_range(0, gap_max)) step();
    end
  endtask

  initial begin
    logic [7:0] w[NC];
    logic [7:0] w2[NC];
    logic [18:0] e;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_min", out_min, 0);
    check("reset_idx", out_idx, 0);
    check("reset_uniq", out_uniq, 0);
    check("reset_in_ready", in_ready, 1);
    step();
    out_ready = 1'b1;

    w = '{8'd9, 8'd7, 8'd7, 8'd8, 8'd5, 8'd5, 8'd6, 8'd9};
    send_window(w, 0, 1'b1);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    step();
    w = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    send_window(w, 0, 1'b1);
    w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_window(w, 0, 1'b1);
    w = '{8'd10, 8'd13, 8'd20, 8'd20, 8'd30, 8'd30, 8'd30, 8'd30};
    send_window(w, 0, 1'b1);
    w = '{8'd10, 8'd12, 8'd20, 8'd20, 8'd30, 8'd30, 8'd30, 8'd30};
    send_window(w, 0, 1'b1);

    step();
    out_ready = 1'b0;
    w = '{8'd50, 8'd44, 8'd61, 8'd44, 8'd70, 8'd45, 8'd90, 8'd80};
    model(w, e);
    send_window(w, 0, 1'b1);
    fork
      begin
        w2 = '{8'd33, 8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd32, 8'd39};
        send_window(w2, 0, 1'b1);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_valid", out_valid, 1);
          check("stall_min", out_min, e[18:11]);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    step(); step();
    w = '{8'd40, 8'd30, 8'd3, 8'd50, 8'd60, 8'd60, 8'd60, 8'd60};
    send_window(w, 0, 1'b1);
    step(); step();
    send_beat({4{8'd1}});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_min", out_min, 0);
    check("rst_idx", out_idx, 0);
    check("rst_uniq", out_uniq, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    step();
    w = '{8'd20, 8'd9, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 8'd8};
    send_window(w, 0, 1'b1);

    step(); step();
    hs_cyc.delete();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NC; i++) w[i] = 8'($urandom_range(0, 15));
      send_window(w, 0, 1'b1);
    end
    step(); step(); step();
    check("burst_count", hs_cyc.size(), 4);
    for (int i = 1; i < 4 && i < hs_cyc.size(); i++)
      check("burst_spacing", hs_cyc[i] - hs_cyc[i-1], BT);

    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      t = ($urandom_range(0, 1) != 0) ? 15 : 255;
      for (int i = 0; i < NC; i++) w[i] = 8'($urandom_range(0, t));
      send_window(w, 2, 1'b1);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (expq.size() != 0 && t < 100) begin
      step();
      t++;
    end
    step();
    check("drain_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
